// File: rtl/qdec_cabac_frame_seq_pkg.sv
// Shared definitions for the CABAC frame sequencer: register map, status codes, FSM states.
// QDEC_CABAC_SEQ_READBACK_EN adds the register read-back states.
package qdec_cabac_package;

   localparam logic [15:0] ADDR_CABAC_START          = 16'h0004;
   localparam logic [15:0] ADDR_CABAC_VPS_0          = 16'h0010;
   localparam logic [15:0] ADDR_CABAC_SPS_0          = 16'h0020;
   localparam logic [15:0] ADDR_CABAC_SPS_1          = 16'h0024;
   localparam logic [15:0] ADDR_CABAC_PPS_0          = 16'h0030;
   localparam logic [15:0] ADDR_CABAC_SLICE_HEADER_0 = 16'h0040;

   localparam int unsigned NUM_CFG_REGS = 5;
   localparam logic [2:0]  LAST_CFG_IDX = 3'd4;

   typedef enum logic [2:0] {
      STAT_OK           = 3'd0,
      STAT_ERROR        = 3'd1,
      STAT_TIMEOUT      = 3'd2,
      STAT_CTU_MISMATCH = 3'd3,
      STAT_ABORTED      = 3'd4,
      STAT_RB_MISMATCH  = 3'd5
   } t_seq_stat_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
`ifdef QDEC_CABAC_SEQ_READBACK_EN
      S_RD_REQ,
      S_RD_RESP,
`endif
      S_START_REQ,
      S_START_RESP,
      S_RUN,
      S_REPORT
   } t_seq_state_e;

   // Programming order of the config registers
   function automatic logic [15:0] cfg_reg_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    cfg_reg_addr = ADDR_CABAC_VPS_0;
         3'd1:    cfg_reg_addr = ADDR_CABAC_SPS_0;
         3'd2:    cfg_reg_addr = ADDR_CABAC_SPS_1;
         3'd3:    cfg_reg_addr = ADDR_CABAC_PPS_0;
         default: cfg_reg_addr = ADDR_CABAC_SLICE_HEADER_0;
      endcase
   endfunction

endpackage

// File: rtl/qdec_cabac_frame_seq_watchdog.sv
// Watchdog counter for the frame sequencer: reload to TIMEOUT_CYC, count down, flag zero.
module qdec_seq_watchdog #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(TIMEOUT_CYC);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/qdec_cabac_frame_seq.sv
// Frame-level sequencer: programs CABAC config registers, starts it, supervises the run, reports status.
// QDEC_CABAC_SEQ_READBACK_EN enables read-back verification of the programmed registers.
module qdec_cabac_frame_seq
   import qdec_cabac_package::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned CTU_CNT_W   = 20,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_vld,
   output logic                 cfg_rdy,
   input  logic [31:0]          cfg_vps0,
   input  logic [31:0]          cfg_sps0,
   input  logic [31:0]          cfg_sps1,
   input  logic [31:0]          cfg_pps0,
   input  logic [31:0]          cfg_slice0,
   input  logic                 abort,
   output logic                 reg_req_vld,
   input  logic                 reg_req_rdy,
   output logic                 reg_req_we,
   output logic [ADDR_W-1:0]    reg_req_addr,
   output logic [31:0]          reg_req_wdata,
   input  logic                 reg_resp_vld,
   input  logic [31:0]          reg_resp_rdata,
   input  logic                 ctu_done_intr,
   input  logic                 done_intr,
   input  logic                 error_intr,
   output logic                 busy,
   output logic                 stat_vld,
   output logic [2:0]           stat_code,
   output logic [CTU_CNT_W-1:0] stat_ctu_cnt
);

   t_seq_state_e         state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [31:0]          cfg_q [NUM_CFG_REGS];
   logic                 cfg_load;
   logic                 abort_pend_q, abort_pend_d;
   logic [CTU_CNT_W-1:0] ctu_cnt_q, ctu_cnt_d;
   logic [CTU_CNT_W-1:0] exp_cnt_q, exp_cnt_d;
   logic [CTU_CNT_W-1:0] stat_cnt_q, stat_cnt_d;
   t_seq_stat_e          stat_code_q, stat_code_d;
   logic                 wd_load, wd_zero;
   logic                 any_intr;
   logic [CTU_CNT_W-1:0] ctu_cnt_nxt;

   logic [11:0] w_m1, h_m1;
   logic [4:0]  log2_ctu;
   logic [12:0] w_ctus, h_ctus;
   logic [25:0] ctu_prod;

   assign w_m1     = cfg_sps0[27:16];
   assign h_m1     = cfg_sps0[15:4];
   assign log2_ctu = {1'b0, cfg_sps1[3:0]} + {1'b0, cfg_sps1[7:4]};
   assign w_ctus   = {1'b0, w_m1 >> log2_ctu} + 13'd1;
   assign h_ctus   = {1'b0, h_m1 >> log2_ctu} + 13'd1;
   assign ctu_prod = 26'(w_ctus) * 26'(h_ctus);

   assign any_intr    = ctu_done_intr | done_intr | error_intr;
   assign ctu_cnt_nxt = (ctu_done_intr && (ctu_cnt_q != '1)) ? ctu_cnt_q + CTU_CNT_W'(1) : ctu_cnt_q;

`ifndef QDEC_CABAC_SEQ_READBACK_EN
   logic unused_rdata;
   assign unused_rdata = ^reg_resp_rdata;
`endif

   qdec_seq_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (wd_load),
      .dec_i  (state_q == S_RUN),
      .zero_o (wd_zero)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      abort_pend_d  = abort_pend_q;
      ctu_cnt_d     = ctu_cnt_q;
      exp_cnt_d     = exp_cnt_q;
      stat_cnt_d    = stat_cnt_q;
      stat_code_d   = stat_code_q;
      cfg_load      = 1'b0;
      wd_load       = 1'b0;
      cfg_rdy       = 1'b0;
      reg_req_vld   = 1'b0;
      reg_req_we    = 1'b0;
      reg_req_addr  = '0;
      reg_req_wdata = '0;
      stat_vld      = 1'b0;
      busy          = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            cfg_rdy = rst_n;
            if (cfg_vld) begin
               cfg_load     = 1'b1;
               idx_d        = '0;
               abort_pend_d = 1'b0;
               ctu_cnt_d    = '0;
               exp_cnt_d    = CTU_CNT_W'(ctu_prod);
               state_d      = S_WR_REQ;
            end
         end

         S_WR_REQ: begin
            reg_req_vld   = 1'b1;
            reg_req_we    = 1'b1;
            reg_req_addr  = ADDR_W'(cfg_reg_addr(idx_q));
            reg_req_wdata = cfg_q[idx_q];
            abort_pend_d  = abort_pend_q | abort;
            if (reg_req_rdy) state_d = S_WR_RESP;
         end

         S_WR_RESP: begin
            abort_pend_d = abort_pend_q | abort;
            if (reg_resp_vld) begin
               // Abort is honoured only once the outstanding response is consumed
               if (abort_pend_q || abort) begin
                  stat_code_d = STAT_ABORTED;
                  stat_cnt_d  = ctu_cnt_q;
                  state_d     = S_REPORT;
               end else if (idx_q == LAST_CFG_IDX) begin
                  idx_d = '0;
`ifdef QDEC_CABAC_SEQ_READBACK_EN
                  state_d = S_RD_REQ;
`else
                  state_d = S_START_REQ;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_WR_REQ;
               end
            end
         end

`ifdef QDEC_CABAC_SEQ_READBACK_EN
         S_RD_REQ: begin
            reg_req_vld  = 1'b1;
            reg_req_addr = ADDR_W'(cfg_reg_addr(idx_q));
            abort_pend_d = abort_pend_q | abort;
            if (reg_req_rdy) state_d = S_RD_RESP;
         end

         S_RD_RESP: begin
            abort_pend_d = abort_pend_q | abort;
            if (reg_resp_vld) begin
               if (abort_pend_q || abort) begin
                  stat_code_d = STAT_ABORTED;
                  stat_cnt_d  = ctu_cnt_q;
                  state_d     = S_REPORT;
               end else if (reg_resp_rdata != cfg_q[idx_q]) begin
                  stat_code_d = STAT_RB_MISMATCH;
                  stat_cnt_d  = ctu_cnt_q;
                  state_d     = S_REPORT;
               end else if (idx_q == LAST_CFG_IDX) begin
                  state_d = S_START_REQ;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_RD_REQ;
               end
            end
         end
`endif

         S_START_REQ: begin
            reg_req_vld   = 1'b1;
            reg_req_we    = 1'b1;
            reg_req_addr  = ADDR_W'(ADDR_CABAC_START);
            reg_req_wdata = 32'h1;
            abort_pend_d  = abort_pend_q | abort;
            if (reg_req_rdy) state_d = S_START_RESP;
         end

         S_START_RESP: begin
            abort_pend_d = abort_pend_q | abort;
            if (reg_resp_vld) begin
               if (abort_pend_q || abort) begin
                  stat_code_d = STAT_ABORTED;
                  stat_cnt_d  = ctu_cnt_q;
                  state_d     = S_REPORT;
               end else begin
                  wd_load = 1'b1;
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            ctu_cnt_d  = ctu_cnt_nxt;
            wd_load    = any_intr;
            stat_cnt_d = ctu_cnt_nxt;
            if (abort) begin
               stat_code_d = STAT_ABORTED;
               state_d     = S_REPORT;
            end else if (error_intr) begin
               stat_code_d = STAT_ERROR;
               state_d     = S_REPORT;
            end else if (wd_zero) begin
               stat_code_d = STAT_TIMEOUT;
               state_d     = S_REPORT;
            end else if (done_intr) begin
               stat_code_d = (ctu_cnt_nxt == exp_cnt_q) ? STAT_OK : STAT_CTU_MISMATCH;
               state_d     = S_REPORT;
            end
         end

         S_REPORT: begin
            stat_vld = 1'b1;
            state_d  = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         abort_pend_q <= 1'b0;
         ctu_cnt_q    <= '0;
         exp_cnt_q    <= '0;
         stat_cnt_q   <= '0;
         stat_code_q  <= STAT_OK;
         for (int unsigned i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         abort_pend_q <= abort_pend_d;
         ctu_cnt_q    <= ctu_cnt_d;
         exp_cnt_q    <= exp_cnt_d;
         stat_cnt_q   <= stat_cnt_d;
         stat_code_q  <= stat_code_d;
         if (cfg_load) begin
            cfg_q[0] <= cfg_vps0;
            cfg_q[1] <= cfg_sps0;
            cfg_q[2] <= cfg_sps1;
            cfg_q[3] <= cfg_pps0;
            cfg_q[4] <= cfg_slice0;
         end
      end
   end

   assign stat_code    = stat_code_q;
   assign stat_ctu_cnt = stat_cnt_q;

endmodule

// File: tb/tb_qdec_cabac_frame_seq.sv
// Directed bench for qdec_cabac_frame_seq with a register-slave model driven on the falling edge.
module tb_qdec_cabac_frame_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_vld = 1'b0;
   logic        cfg_rdy;
   logic [31:0] cfg_vps0 = '0, cfg_sps0 = '0, cfg_sps1 = '0, cfg_pps0 = '0, cfg_slice0 = '0;
   logic        abort = 1'b0;
   logic        reg_req_vld, reg_req_we;
   logic        reg_req_rdy = 1'b0;
   logic [15:0] reg_req_addr;
   logic [31:0] reg_req_wdata;
   logic        reg_resp_vld = 1'b0;
   logic [31:0] reg_resp_rdata = '0;
   logic        ctu_done_intr = 1'b0, done_intr = 1'b0, error_intr = 1'b0;
   logic        busy, stat_vld;
   logic [2:0]  stat_code;
   logic [19:0] stat_ctu_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   qdec_cabac_frame_seq #(
      .ADDR_W(16), .CTU_CNT_W(20), .TIMEOUT_CYC(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
      .cfg_vps0(cfg_vps0), .cfg_sps0(cfg_sps0), .cfg_sps1(cfg_sps1),
      .cfg_pps0(cfg_pps0), .cfg_slice0(cfg_slice0), .abort(abort),
      .reg_req_vld(reg_req_vld), .reg_req_rdy(reg_req_rdy), .reg_req_we(reg_req_we),
      .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
      .reg_resp_vld(reg_resp_vld), .reg_resp_rdata(reg_resp_rdata),
      .ctu_done_intr(ctu_done_intr), .done_intr(done_intr), .error_intr(error_intr),
      .busy(busy), .stat_vld(stat_vld), .stat_code(stat_code), .stat_ctu_cnt(stat_ctu_cnt)
   );

   // Register slave: rdy after rdy_delay cycles, response the cycle after the handshake
   int          rdy_delay = 0;
   int          waitc = 0;
   int          proto_viol = 0;
   int          reads = 0;
   bit          outstanding = 0, vld_seen = 0, rb_zero_pps = 0;
   logic [15:0] cap_addr = '0;
   logic        cap_we = 1'b0;
   logic [31:0] cap_data = '0;
   logic [31:0] mem [0:255];
   logic [15:0] wlog_addr [$];
   logic [31:0] wlog_data [$];

   initial for (int i = 0; i < 256; i++) mem[i] = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         reg_req_rdy = 1'b0; reg_resp_vld = 1'b0; outstanding = 0; vld_seen = 0; waitc = 0;
      end else begin
         if (reg_resp_vld) outstanding = 0;
         reg_resp_vld = 1'b0;
         if (vld_seen && reg_req_rdy) begin
            if (cap_we) begin
               wlog_addr.push_back(cap_addr);
               wlog_data.push_back(cap_data);
               mem[cap_addr[7:0]] = cap_data;
               reg_resp_rdata = '0;
            end else begin
               reads++;
               reg_resp_rdata = (rb_zero_pps && cap_addr == 16'h0030) ? 32'h0 : mem[cap_addr[7:0]];
            end
            reg_resp_vld = 1'b1;
            outstanding = 1;
            waitc = 0;
         end else if (vld_seen) begin
            if (!reg_req_vld || reg_req_addr !== cap_addr || reg_req_we !== cap_we || reg_req_wdata !== cap_data)
               proto_viol++;
         end
         if (reg_req_vld && outstanding) proto_viol++;
         reg_req_rdy = 1'b0;
         if (reg_req_vld && !outstanding) begin
            if (waitc >= rdy_delay) reg_req_rdy = 1'b1;
            else waitc++;
         end
         vld_seen = reg_req_vld;
         cap_addr = reg_req_addr;
         cap_we   = reg_req_we;
         cap_data = reg_req_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cfg(input logic [31:0] pps);
      cfg_vps0   = 32'h1111_2222;
      cfg_sps0   = 32'h033F_1DF0;   // w_m1=831, h_m1=479
      cfg_sps1   = 32'h0000_0033;   // log2MinCb=3, diff=3
      cfg_pps0   = pps;
      cfg_slice0 = 32'h5555_0001;
      cfg_vld    = 1'b1;
      @(negedge clk);
      cfg_vld    = 1'b0;
   endtask

   task automatic wait_run(input int base, output bit ok);
      int cyc = 0;
      while (wlog_addr.size() < base + 6 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      ok = (wlog_addr.size() >= base + 6);
      @(negedge clk);
   endtask

   task automatic ctu_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         ctu_done_intr = 1'b1;
         @(negedge clk);
      end
      ctu_done_intr = 1'b0;
   endtask

   task automatic wait_stat(input int budget, output bit seen);
      int cyc = 0;
      seen = stat_vld;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         seen = stat_vld;
      end
   endtask

   initial begin
      bit ok;
      bit seen;
      int base;
      logic [15:0] exp_addr [6];
      logic [31:0] exp_data [6];

      exp_addr = '{16'h0010, 16'h0020, 16'h0024, 16'h0030, 16'h0040, 16'h0004};
      exp_data = '{32'h1111_2222, 32'h033F_1DF0, 32'h0000_0033, 32'h001A_4209, 32'h5555_0001, 32'h1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_stat_vld", 32'(stat_vld), 32'h0);
      check("rst_stat_code", 32'(stat_code), 32'h0);
      check("rst_stat_cnt", 32'(stat_ctu_cnt), 32'h0);
      check("rst_req_vld", 32'(reg_req_vld), 32'h0);
      check("rst_cfg_rdy", 32'(cfg_rdy), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_cfg_rdy", 32'(cfg_rdy), 32'h1);

      // Frame 1: slow slave, write order and protocol, 104 CTUs -> OK
      rdy_delay = 20;
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      check("accept_busy", 32'(busy), 32'h1);
      check("accept_cfg_rdy", 32'(cfg_rdy), 32'h0);
      wait_run(base, ok);
      check("f1_run_reached", 32'(ok), 32'h1);
      for (int i = 0; i < 6; i++) begin
         if (base + i < wlog_addr.size()) begin
            check($sformatf("f1_wr%0d_addr", i), 32'(wlog_addr[base + i]), 32'(exp_addr[i]));
            check($sformatf("f1_wr%0d_data", i), wlog_data[base + i], exp_data[i]);
         end
      end
      check("f1_protocol", 32'(proto_viol), 32'h0);
      ctu_pulses(104);
      done_intr = 1'b1;
      @(negedge clk);
      done_intr = 1'b0;
      wait_stat(20, seen);
      check("f1_stat_seen", 32'(seen), 32'h1);
      check("f1_code_ok", 32'(stat_code), 32'h0);
      check("f1_cnt", 32'(stat_ctu_cnt), 32'd104);
      @(negedge clk);
      check("f1_stat_vld_pulse", 32'(stat_vld), 32'h0);
      check("f1_idle", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      check("f1_code_held", 32'(stat_code), 32'h0);

      // Frame 2: 103 CTUs then done -> CTU_MISMATCH
      rdy_delay = 0;
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      wait_run(base, ok);
      check("f2_run_reached", 32'(ok), 32'h1);
      ctu_pulses(103);
      done_intr = 1'b1;
      @(negedge clk);
      done_intr = 1'b0;
      wait_stat(20, seen);
      check("f2_stat_seen", 32'(seen), 32'h1);
      check("f2_code_mismatch", 32'(stat_code), 32'h3);
      check("f2_cnt", 32'(stat_ctu_cnt), 32'd103);

      // Frame 3: 104th CTU in the same cycle as done -> OK
      @(negedge clk);
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      wait_run(base, ok);
      check("f3_run_reached", 32'(ok), 32'h1);
      ctu_pulses(103);
      ctu_done_intr = 1'b1;
      done_intr = 1'b1;
      @(negedge clk);
      ctu_done_intr = 1'b0;
      done_intr = 1'b0;
      wait_stat(20, seen);
      check("f3_stat_seen", 32'(seen), 32'h1);
      check("f3_code_ok", 32'(stat_code), 32'h0);
      check("f3_cnt", 32'(stat_ctu_cnt), 32'd104);

      // Frame 4: error and done together at CTU 50 -> ERROR
      @(negedge clk);
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      wait_run(base, ok);
      check("f4_run_reached", 32'(ok), 32'h1);
      ctu_pulses(50);
      error_intr = 1'b1;
      done_intr = 1'b1;
      @(negedge clk);
      error_intr = 1'b0;
      done_intr = 1'b0;
      wait_stat(20, seen);
      check("f4_stat_seen", 32'(seen), 32'h1);
      check("f4_code_error", 32'(stat_code), 32'h1);
      check("f4_cnt", 32'(stat_ctu_cnt), 32'd50);

      // Frame 5: silence -> TIMEOUT
      @(negedge clk);
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      wait_run(base, ok);
      check("f5_run_reached", 32'(ok), 32'h1);
      wait_stat(900, seen);
      check("f5_no_early_timeout", 32'(seen), 32'h0);
      wait_stat(300, seen);
      check("f5_stat_seen", 32'(seen), 32'h1);
      check("f5_code_timeout", 32'(stat_code), 32'h2);
      check("f5_cnt", 32'(stat_ctu_cnt), 32'd0);

      // Frame 6: abort while the SPS1 write is pending -> ABORTED, no START
      @(negedge clk);
      rdy_delay = 5;
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      begin
         int cyc = 0;
         while (wlog_addr.size() < base + 2 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
         end
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_stat(200, seen);
      check("f6_stat_seen", 32'(seen), 32'h1);
      check("f6_code_aborted", 32'(stat_code), 32'h4);
      check("f6_cnt", 32'(stat_ctu_cnt), 32'd0);
      check("f6_write_count", 32'(wlog_addr.size() - base), 32'd3);
      check("f6_last_addr_sps1", 32'(wlog_addr[wlog_addr.size() - 1]), 32'h0024);
      check("f6_protocol", 32'(proto_viol), 32'h0);
      @(negedge clk);
      check("f6_cfg_rdy", 32'(cfg_rdy), 32'h1);

      // Frame 7: next descriptor after abort runs normally
      rdy_delay = 0;
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      wait_run(base, ok);
      check("f7_run_reached", 32'(ok), 32'h1);
      check("f7_start_addr", 32'(wlog_addr[wlog_addr.size() - 1]), 32'h0004);
      ctu_pulses(104);
      done_intr = 1'b1;
      @(negedge clk);
      done_intr = 1'b0;
      wait_stat(20, seen);
      check("f7_stat_seen", 32'(seen), 32'h1);
      check("f7_code_ok", 32'(stat_code), 32'h0);
      check("f7_cnt", 32'(stat_ctu_cnt), 32'd104);

`ifdef QDEC_CABAC_SEQ_READBACK_EN
      // Frame 8: PPS0 reads back zero -> RB_MISMATCH, no START
      @(negedge clk);
      rb_zero_pps = 1;
      reads = 0;
      base = wlog_addr.size();
      send_cfg(32'h001A_4209);
      wait_stat(500, seen);
      rb_zero_pps = 0;
      check("f8_stat_seen", 32'(seen), 32'h1);
      check("f8_code_rb", 32'(stat_code), 32'h5);
      check("f8_write_count", 32'(wlog_addr.size() - base), 32'd5);
      check("f8_read_count", 32'(reads), 32'd4);
`endif

      check("final_protocol", 32'(proto_viol), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
